galaxian_input_cond: RTL and testbench

//  Conditions raw cabinet/board switch inputs into the 9-bit I_SW vector consumed by galaxian_top.

---
 rtl/galaxian_input_cond.sv | 160 ++++++++++++++++
 tb/tb_galaxian_input_cond.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/galaxian_input_cond.sv
// Input conditioning for galaxian_top: synchronise, fix polarity, debounce,
// and turn the two coin switches into fixed-width, lockout-protected pulses
// that are also totalled on an 8-bit display counter.
module galaxian_input_cond #(
    parameter logic [8:0] INV_MASK          = 9'h060,
    parameter int         DEB_CYCLES        = 368640,
    parameter int         COIN_PULSE_CYCLES = 3686400,
    parameter int         COIN_LOCK_CYCLES  = 7372800
) (
    input  logic       CLK_36M,
    input  logic       I_RESET,
    input  logic [8:0] I_RAW,
    output logic [8:0] O_SW,
    output logic [7:0] O_COIN_CNT
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);

    localparam int TMAX = (COIN_PULSE_CYCLES > COIN_LOCK_CYCLES) ? COIN_PULSE_CYCLES : COIN_LOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LOAD = TW'(COIN_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'((COIN_LOCK_CYCLES > 0) ? (COIN_LOCK_CYCLES - 1) : 0);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    // A coin held through reset reaches the debounced level DEB_CYCLES+2
    // edges after release; ARM must not be left before that point or the
    // held coin would look like a fresh insertion.
    localparam int STARTUP = DEB_CYCLES + 2;
    localparam int SUW     = $clog2(STARTUP + 1);
    localparam logic [SUW-1:0] STARTUP_LAST = SUW'(STARTUP);
    localparam logic [SUW-1:0] STARTUP_ONE  = SUW'(1);

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        PULSE = 2'd2,
        LOCK  = 2'd3
    } coin_state_t;

    logic [8:0]    sync1;
    logic [8:0]    sync2;
    logic [8:0]    level;
    logic [DW-1:0] deb_cnt [9];
    logic [SUW-1:0] startup;
    logic          ready;
    logic [1:0]    coin_lvl;
    logic [1:0]    coin_prev;
    coin_state_t   state      [2];
    coin_state_t   state_next [2];
    logic [TW-1:0] timer      [2];
    logic [TW-1:0] timer_next [2];
    logic [1:0]    enter_pulse;

    assign coin_lvl = {level[8], level[6]};
    assign ready    = (startup == STARTUP_LAST);

    // Two-flop synchroniser with the active-low inputs flipped up front
    always_ff @(posedge CLK_36M) begin
        if (I_RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= I_RAW ^ INV_MASK;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: a new level must be seen on DEB_CYCLES consecutive edges
    always_ff @(posedge CLK_36M) begin
        if (I_RESET) begin
            level <= '0;
            for (int k = 0; k < 9; k++) deb_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (sync2[k] == level[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    level[k]   <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DEB_ONE;
                end
            end
        end
    end

    // Saturating post-reset counter that gates the ARM -> IDLE exit
    always_ff @(posedge CLK_36M) begin
        if (I_RESET) begin
            startup <= '0;
        end else if (startup != STARTUP_LAST) begin
            startup <= startup + STARTUP_ONE;
        end
    end

    // Coin FSM next-state: edge-triggered pulse, then lockout, then re-arm
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_next[i]  = state[i];
            timer_next[i]  = timer[i];
            enter_pulse[i] = 1'b0;
            case (state[i])
                ARM: begin
                    if (ready && !coin_lvl[i]) state_next[i] = IDLE;
                end
                IDLE: begin
                    if (coin_lvl[i] && !coin_prev[i]) begin
                        state_next[i]  = PULSE;
                        timer_next[i]  = PULSE_LOAD;
                        enter_pulse[i] = 1'b1;
                    end
                end
                PULSE: begin
                    if (timer[i] == '0) begin
                        if (COIN_LOCK_CYCLES == 0) begin
                            state_next[i] = IDLE;
                        end else begin
                            state_next[i] = LOCK;
                            timer_next[i] = LOCK_LOAD;
                        end
                    end else begin
                        timer_next[i] = timer[i] - TIMER_ONE;
                    end
                end
                LOCK: begin
                    if (timer[i] == '0) begin
                        state_next[i] = coin_lvl[i] ? ARM : IDLE;
                    end else begin
                        timer_next[i] = timer[i] - TIMER_ONE;
                    end
                end
                default: state_next[i] = ARM;
            endcase
        end
    end

    // FSM registers, coin counter and the registered switch outputs
    always_ff @(posedge CLK_36M) begin
        if (I_RESET) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= ARM;
                timer[i] <= '0;
            end
            coin_prev  <= '0;
            O_COIN_CNT <= '0;
            O_SW       <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_next[i];
                timer[i] <= timer_next[i];
            end
            coin_prev  <= coin_lvl;
            O_COIN_CNT <= O_COIN_CNT + {7'd0, enter_pulse[0]} + {7'd0, enter_pulse[1]};
            O_SW       <= {state_next[1] == PULSE, level[7], state_next[0] == PULSE, level[5:0]};
        end
    end

endmodule

// File: tb/tb_galaxian_input_cond.sv
// Randomised bench for galaxian_input_cond against a timeline reference model.
module tb_galaxian_input_cond;

    localparam int DEB  = 4;
    localparam int P    = 8;
    localparam int L    = 16;
    localparam int MAXE = 32768;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] raw;
    logic [8:0] sw;
    logic [7:0] cnt;

    int checks = 0;
    int errors = 0;

    // reference model state (indexed by clock edge number)
    int       t = 0;
    bit [8:0] raw_h [0:MAXE-1];
    bit       rst_h [0:MAXE-1];
    bit [8:0] ss_h  [0:MAXE-1];
    bit [8:0] d_m;
    bit [8:0] sw_m;
    bit [7:0] cnt_m;
    int       last_rst = 0;
    int       free_at [2];
    int       start_e [2];
    bit       started [2];
    bit       rise_prev [2];

    galaxian_input_cond #(
        .INV_MASK(9'h000),
        .DEB_CYCLES(DEB),
        .COIN_PULSE_CYCLES(P),
        .COIN_LOCK_CYCLES(L)
    ) dut (
        .CLK_36M(clk),
        .I_RESET(rst),
        .I_RAW(raw),
        .O_SW(sw),
        .O_COIN_CNT(cnt)
    );

    always #5 clk = ~clk;

    // One clock edge plus the model's view of what that edge must produce.
    // A level change is accepted when the synchronised input showed the new
    // value on DEB consecutive post-reset edges; a coin pulse starts the edge
    // after its debounced rise if the rise happened at/after the coin's free time.
    task automatic tick();
        bit [8:0] nd;
        bit ok;
        int u;
        int cb;
        @(posedge clk);
        t++;
        if (t >= MAXE) begin
            $display("[TB] FAIL model_overflow t=%0d limit %0d", t, MAXE);
            $fatal(1, "[TB] model history exhausted");
        end
        raw_h[t] = raw;
        rst_h[t] = rst;
        #1;
        if (rst) begin
            d_m = '0; sw_m = '0; cnt_m = '0; ss_h[t] = '0; last_rst = t;
            for (int i = 0; i < 2; i++) begin
                started[i] = 0; rise_prev[i] = 0; free_at[i] = t + DEB + 3;
            end
        end else begin
            ss_h[t] = (t < 3 || rst_h[t-1] || rst_h[t-2]) ? 9'h000 : raw_h[t-2];
            for (int i = 0; i < 2; i++) begin
                if (rise_prev[i] && (t - 1) >= free_at[i]) begin
                    started[i] = 1; start_e[i] = t; free_at[i] = t + P + L;
                    cnt_m = cnt_m + 8'd1;
                end
            end
            sw_m = d_m;
            sw_m[6] = started[0] && (t - start_e[0] < P);
            sw_m[8] = started[1] && (t - start_e[1] < P);
            nd = d_m;
            for (int k = 0; k < 9; k++) begin
                if (ss_h[t][k] != d_m[k]) begin
                    ok = 1;
                    for (int j = 0; j < DEB; j++) begin
                        u = t - j;
                        if (u <= last_rst) ok = 0;
                        else if (ss_h[u][k] != ss_h[t][k]) ok = 0;
                    end
                    if (ok) nd[k] = ss_h[t][k];
                end
            end
            for (int i = 0; i < 2; i++) begin
                cb = (i == 0) ? 6 : 8;
                rise_prev[i] = nd[cb] && !d_m[cb];
            end
            d_m = nd;
        end
    endtask

    task automatic run_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw = 9'h1FF;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (sw !== 9'h000) begin errors++; $display("[TB] FAIL reset_sw got %h exp 000", sw); end
            checks++;
            if (cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_cnt got %h exp 00", cnt); end
        end
        rst = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            checks++;
            if (sw !== sw_m) begin errors++; $display("[TB] FAIL rel_sw e=%0d got %h exp %h", e, sw, sw_m); end
            checks++;
            if (cnt !== 8'h00) begin errors++; $display("[TB] FAIL rel_cnt e=%0d got %h exp 00", e, cnt); end
            if (e == 6) begin
                checks++;
                if (sw !== 9'h000) begin errors++; $display("[TB] FAIL rel_early got %h exp 000", sw); end
            end
            if (e == 7) begin
                checks++;
                if (sw !== 9'h0BF) begin errors++; $display("[TB] FAIL rel_level got %h exp 0BF", sw); end
            end
        end
        raw = 9'h000;
        for (int e = 0; e < 12; e++) begin
            tick();
            checks++;
            if (sw !== sw_m) begin errors++; $display("[TB] FAIL rel_drop_sw got %h exp %h", sw, sw_m); end
        end
    endtask

    task automatic test_debounce();
        bit [8:0] m;
        raw = 9'h000;
        for (int e = 1; e <= 14; e++) begin
            raw[2] = (e <= 3);
            tick();
            checks++;
            if (sw[2] !== 1'b0) begin errors++; $display("[TB] FAIL glitch3 e=%0d got %b exp 0", e, sw[2]); end
        end
        for (int e = 1; e <= 16; e++) begin
            raw[2] = (e <= 4);
            tick();
            checks++;
            if (sw !== sw_m) begin errors++; $display("[TB] FAIL hold4_sw e=%0d got %h exp %h", e, sw, sw_m); end
            if (e == 6 || e == 7 || e == 10 || e == 11) begin
                checks++;
                if (sw[2] !== (e == 7 || e == 10)) begin
                    errors++; $display("[TB] FAIL hold4_edge e=%0d got %b exp %b", e, sw[2], (e == 7 || e == 10));
                end
            end
        end
        for (int e = 0; e < 300; e++) begin
            m = '0;
            for (int k = 0; k < 9; k++)
                if (k != 6 && k != 8 && $urandom_range(0, 4) == 0) m[k] = 1'b1;
            raw = raw ^ m;
            tick();
            checks++;
            if (sw !== sw_m) begin errors++; $display("[TB] FAIL rand_deb t=%0d got %h exp %h", t, sw, sw_m); end
        end
        raw = 9'h000;
        repeat (10) tick();
    endtask

    task automatic test_coin_hold();
        int first_hi;
        int width;
        run_reset(2);
        raw = 9'h000;
        repeat (12) tick();
        first_hi = -1;
        width = 0;
        for (int e = 1; e <= 60; e++) begin
            raw[6] = 1'b1;
            tick();
            if (sw[6] === 1'b1) begin
                width++;
                if (first_hi < 0) first_hi = e;
            end
            checks++;
            if (sw !== sw_m) begin errors++; $display("[TB] FAIL hold_sw e=%0d got %h exp %h", e, sw, sw_m); end
        end
        checks++;
        if (first_hi != 7) begin errors++; $display("[TB] FAIL hold_start got %0d exp 7", first_hi); end
        checks++;
        if (width != P) begin errors++; $display("[TB] FAIL hold_width got %0d exp %0d", width, P); end
        checks++;
        if (cnt !== 8'd1) begin errors++; $display("[TB] FAIL hold_cnt got %0d exp 1", cnt); end
        raw = 9'h000;
        for (int e = 0; e < 40; e++) begin
            tick();
            checks++;
            if (sw[6] !== 1'b0) begin errors++; $display("[TB] FAIL hold_repulse e=%0d got %b exp 0", e, sw[6]); end
        end
    endtask

    task automatic test_coin_taps();
        int pulses;
        logic prev;
        run_reset(2);
        raw = 9'h000;
        repeat (12) tick();
        pulses = 0;
        prev = 1'b0;
        for (int e = 1; e <= 80; e++) begin
            raw[6] = (e <= 6) || (e >= 16 && e <= 21) || (e >= 40 && e <= 45);
            tick();
            if (sw[6] === 1'b1 && prev !== 1'b1) pulses++;
            prev = sw[6];
            checks++;
            if (sw !== sw_m) begin errors++; $display("[TB] FAIL taps_sw e=%0d got %h exp %h", e, sw, sw_m); end
            if (e == 35) begin
                checks++;
                if (cnt !== 8'd1) begin errors++; $display("[TB] FAIL taps_lock_cnt got %0d exp 1", cnt); end
            end
        end
        checks++;
        if (pulses != 2) begin errors++; $display("[TB] FAIL taps_pulses got %0d exp 2", pulses); end
        checks++;
        if (cnt !== 8'd2) begin errors++; $display("[TB] FAIL taps_cnt got %0d exp 2", cnt); end
    endtask

    task automatic test_coin_wrap();
        int w6;
        int w8;
        run_reset(2);
        raw = 9'h000;
        repeat (12) tick();
        for (int it = 0; it < 127; it++) begin
            for (int e = 1; e <= 40; e++) begin
                raw[6] = (e <= 6);
                raw[8] = (e <= 6);
                tick();
                checks++;
                if (cnt !== cnt_m) begin errors++; $display("[TB] FAIL wrap_pre_cnt t=%0d got %0d exp %0d", t, cnt, cnt_m); end
            end
        end
        checks++;
        if (cnt !== 8'd254) begin errors++; $display("[TB] FAIL wrap_preload got %0d exp 254", cnt); end
        w6 = 0;
        w8 = 0;
        for (int e = 1; e <= 40; e++) begin
            raw[6] = (e <= 6);
            raw[8] = (e <= 6);
            tick();
            if (sw[6] === 1'b1) w6++;
            if (sw[8] === 1'b1) w8++;
            checks++;
            if (sw[6] !== sw[8]) begin errors++; $display("[TB] FAIL wrap_phase e=%0d got %b exp %b", e, sw[8], sw[6]); end
            checks++;
            if (sw !== sw_m) begin errors++; $display("[TB] FAIL wrap_sw e=%0d got %h exp %h", e, sw, sw_m); end
        end
        checks++;
        if (w6 != P || w8 != P) begin errors++; $display("[TB] FAIL wrap_width got %0d/%0d exp %0d", w6, w8, P); end
        checks++;
        if (cnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_cnt got %0d exp 0", cnt); end
    endtask

    task automatic test_reset_mid_pulse();
        int hi;
        int waited;
        run_reset(2);
        raw = 9'h000;
        repeat (12) tick();
        raw[6] = 1'b1;
        hi = 0;
        waited = 0;
        while (hi < 3 && waited < 30) begin
            tick();
            waited++;
            if (sw[6] === 1'b1) hi++;
        end
        checks++;
        if (hi < 3) begin errors++; $display("[TB] FAIL mid_wait got %0d high edges exp 3", hi); end
        rst = 1'b1;
        tick();
        checks++;
        if (sw[6] !== 1'b0) begin errors++; $display("[TB] FAIL mid_abort got %b exp 0", sw[6]); end
        checks++;
        if (cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_cnt got %0d exp 0", cnt); end
        tick();
        rst = 1'b0;
        for (int e = 0; e < 60; e++) begin
            tick();
            checks++;
            if (sw[6] !== 1'b0) begin errors++; $display("[TB] FAIL mid_armed e=%0d got %b exp 0", e, sw[6]); end
            checks++;
            if (sw !== sw_m) begin errors++; $display("[TB] FAIL mid_sw e=%0d got %h exp %h", e, sw, sw_m); end
        end
        raw = 9'h000;
        repeat (10) tick();
    endtask

    task automatic test_back_to_back();
        bit [8:0] m;
        run_reset(2);
        raw = 9'h000;
        for (int e = 0; e < 3000; e++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
            end else begin
                rst = 1'b0;
                m = '0;
                for (int k = 0; k < 9; k++)
                    if ($urandom_range(0, 5) == 0) m[k] = 1'b1;
                raw = raw ^ m;
            end
            tick();
            checks++;
            if (sw !== sw_m) begin errors++; $display("[TB] FAIL rand_sw t=%0d got %h exp %h", t, sw, sw_m); end
            checks++;
            if (cnt !== cnt_m) begin errors++; $display("[TB] FAIL rand_cnt t=%0d got %0d exp %0d", t, cnt, cnt_m); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        raw = 9'h000;
        $display("[TB] galaxian_input_cond bench start");
        test_reset();
        test_debounce();
        test_coin_hold();
        test_coin_taps();
        test_coin_wrap();
        test_reset_mid_pulse();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
